// File: rtl/epu_axil_cmd_master.sv
// AXI-Lite command master: turns a write/read/poll command stream into single
// outstanding AXI-Lite transactions and returns one response per command.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/ready, cmd_op/addr/data  command in (op 00 wr, 01 rd, 10 poll, 11 illegal)
//   rsp_valid/ready, rsp_op/data/err   response out (held until rsp_ready)
//   m_axi_aw*/w*/b*/ar*/r*             AXI-Lite master channels
module epu_axil_cmd_master #(
   parameter int unsigned AXI_AW     = 32,
   parameter int unsigned POLL_LIMIT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [AXI_AW-1:0] cmd_addr,
   input  logic [31:0]       cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_op,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic [AXI_AW-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [31:0]       m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [AXI_AW-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [31:0]       m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   localparam int unsigned CNT_W = $clog2(POLL_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);

   localparam logic [1:0] OP_WR   = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_POLL = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_RESP,
      S_RSP
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [31:0]        mask_q, mask_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               cmd_ready_d;
   logic               rsp_valid_d;
   logic [1:0]         rsp_op_d;
   logic [31:0]        rsp_data_d;
   logic               rsp_err_d;
   logic [AXI_AW-1:0]  awaddr_d;
   logic               awvalid_d;
   logic [31:0]        wdata_d;
   logic [3:0]         wstrb_d;
   logic               wvalid_d;
   logic               bready_d;
   logic [AXI_AW-1:0]  araddr_d;
   logic               arvalid_d;
   logic               rready_d;
   logic               aw_done;
   logic               w_done;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         mask_q        <= '0;
         cnt_q         <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_op        <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         mask_q        <= mask_d;
         cnt_q         <= cnt_d;
         cmd_ready     <= cmd_ready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_op        <= rsp_op_d;
         rsp_data      <= rsp_data_d;
         rsp_err       <= rsp_err_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wstrb   <= wstrb_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= bready_d;
         m_axi_araddr  <= araddr_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_rready  <= rready_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready;
      rsp_valid_d = rsp_valid;
      rsp_op_d    = rsp_op;
      rsp_data_d  = rsp_data;
      rsp_err_d   = rsp_err;
      awaddr_d    = m_axi_awaddr;
      awvalid_d   = m_axi_awvalid;
      wdata_d     = m_axi_wdata;
      wstrb_d     = m_axi_wstrb;
      wvalid_d    = m_axi_wvalid;
      bready_d    = m_axi_bready;
      araddr_d    = m_axi_araddr;
      arvalid_d   = m_axi_arvalid;
      rready_d    = m_axi_rready;
      // A channel is done once its valid has dropped or is handshaking now
      aw_done     = !m_axi_awvalid || m_axi_awready;
      w_done      = !m_axi_wvalid  || m_axi_wready;

      unique case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               op_d        = cmd_op;
               mask_d      = cmd_data;
               case (cmd_op)
                  OP_WR: begin
                     state_d   = S_WR_REQ;
                     awaddr_d  = cmd_addr;
                     wdata_d   = cmd_data;
                     wstrb_d   = 4'hF;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                  end
                  OP_RD, OP_POLL: begin
                     state_d   = S_RD_REQ;
                     araddr_d  = cmd_addr;
                     arvalid_d = 1'b1;
                     cnt_d     = '0;
                  end
                  default: begin
                     // Illegal op: answer with an error, no bus traffic
                     state_d     = S_RSP;
                     rsp_valid_d = 1'b1;
                     rsp_op_d    = cmd_op;
                     rsp_data_d  = '0;
                     rsp_err_d   = 1'b1;
                  end
               endcase
            end
         end

         S_WR_REQ: begin
            if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end
         end

         S_WR_RESP: begin
            if (m_axi_bvalid && m_axi_bready) begin
               bready_d    = 1'b0;
               state_d     = S_RSP;
               rsp_valid_d = 1'b1;
               rsp_op_d    = op_q;
               rsp_data_d  = '0;
               rsp_err_d   = (m_axi_bresp != 2'b00);
            end
         end

         S_RD_REQ: begin
            if (m_axi_arvalid && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_RESP;
            end
         end

         S_RD_RESP: begin
            if (m_axi_rvalid && m_axi_rready) begin
               rready_d   = 1'b0;
               rsp_data_d = m_axi_rdata;
               rsp_op_d   = op_q;
               if (op_q != OP_POLL || m_axi_rresp != 2'b00) begin
                  state_d     = S_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = (m_axi_rresp != 2'b00);
               end else if ((m_axi_rdata & mask_q) != 32'h0) begin
                  state_d     = S_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  // Poll timeout after POLL_LIMIT reads
                  state_d     = S_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  cnt_d     = cnt_q + CNT_W'(1);
                  arvalid_d = 1'b1;
                  state_d   = S_RD_REQ;
               end
            end
         end

         S_RSP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_epu_axil_cmd_master.sv
// Directed self-checking bench for epu_axil_cmd_master with a small
// configurable AXI-Lite slave (ready delays, response codes, read sequences).
module tb_epu_axil_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr, cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_op;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   epu_axil_cmd_master #(.AXI_AW(32), .POLL_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   // ---------------- slave model ----------------
   int          aw_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [1:0]  rresp_cfg = 2'b00;
   logic        b_stall = 1'b0;
   logic        seq_en = 1'b0;
   logic [31:0] seq [4];
   int          seq_base = 0;

   int          aw_wait;
   logic        got_aw, got_w;
   logic [31:0] aw_addr_l, w_data_l;
   logic [3:0]  w_strb_l;
   logic [31:0] mem [16];
   int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0;
   int          awv_n = 0, wv_n = 0, bus_n = 0;

   logic        aw_hs, w_hs, ar_hs, have_aw, have_w;
   logic [31:0] aw_a, w_d;
   int          seq_idx;

   assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
   assign m_axi_wready  = m_axi_wvalid;
   assign m_axi_arready = m_axi_arvalid;
   assign aw_hs   = m_axi_awvalid && m_axi_awready;
   assign w_hs    = m_axi_wvalid && m_axi_wready;
   assign ar_hs   = m_axi_arvalid && m_axi_arready;
   assign have_aw = got_aw || aw_hs;
   assign have_w  = got_w || w_hs;
   assign aw_a    = aw_hs ? m_axi_awaddr : aw_addr_l;
   assign w_d     = w_hs ? m_axi_wdata : w_data_l;
   assign seq_idx = (ar_hs_n - seq_base > 3) ? 3 : (ar_hs_n - seq_base);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait      <= 0;
         got_aw       <= 1'b0;
         got_w        <= 1'b0;
         m_axi_bvalid <= 1'b0;
         m_axi_bresp  <= 2'b00;
         m_axi_rvalid <= 1'b0;
         m_axi_rdata  <= 32'h0;
         m_axi_rresp  <= 2'b00;
      end else begin
         if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
         else aw_wait <= 0;
         if (aw_hs) aw_addr_l <= m_axi_awaddr;
         if (w_hs) begin
            w_data_l <= m_axi_wdata;
            w_strb_l <= m_axi_wstrb;
         end
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (have_aw && have_w && !b_stall && !m_axi_bvalid) begin
            m_axi_bvalid    <= 1'b1;
            m_axi_bresp     <= bresp_cfg;
            mem[aw_a[5:2]]  <= w_d;
            got_aw          <= 1'b0;
            got_w           <= 1'b0;
         end else begin
            if (aw_hs) got_aw <= 1'b1;
            if (w_hs)  got_w  <= 1'b1;
         end
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
         if (ar_hs) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rresp  <= rresp_cfg;
            m_axi_rdata  <= seq_en ? seq[seq_idx] : mem[m_axi_araddr[5:2]];
         end
      end
   end

   // Free-running traffic counters (not reset, so tests take deltas)
   always @(posedge clk) begin
      if (aw_hs) aw_hs_n <= aw_hs_n + 1;
      if (w_hs)  w_hs_n  <= w_hs_n + 1;
      if (m_axi_bvalid && m_axi_bready) b_hs_n <= b_hs_n + 1;
      if (ar_hs) ar_hs_n <= ar_hs_n + 1;
      if (m_axi_awvalid) awv_n <= awv_n + 1;
      if (m_axi_wvalid)  wv_n  <= wv_n + 1;
      if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_bready || m_axi_rready)
         bus_n <= bus_n + 1;
   end

   // ---------------- command / response helpers ----------------
   // Called at a negedge; returns at the negedge after the command handshake.
   task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, output int c0);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
      end
      c0 = cyc;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_data = 32'h0;
   endtask

   // Waits for rsp_valid, captures it; if rsp_ready is high, steps past the
   // handshake and expects cmd_ready back the next cycle.
   task automatic get_rsp(output logic [1:0] op, output logic [31:0] d,
                          output logic e, output int c);
      int n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL rsp_wait: rsp_valid=%b required 1 within 100 cycles", rsp_valid);
      end
      op = rsp_op; d = rsp_data; e = rsp_err; c = cyc;
      if (rsp_ready) begin
         @(negedge clk);
         checks++;
         if ({cmd_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rsp_done: cmd_ready,rsp_valid=%b required 10", {cmd_ready, rsp_valid});
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_err, m_axi_awvalid, m_axi_wvalid,
           m_axi_bready, m_axi_arvalid, m_axi_rready} !== 42'h0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy=%b rv=%b op=%h d=%h e=%b vals=%b%b%b%b%b required all 0",
                  cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_err, m_axi_awvalid,
                  m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready);
      end
      checks++;
      if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== 100'h0) begin
         errors++;
         $display("FAIL reset_bus: aw=%h ar=%h wd=%h ws=%h required 0",
                  m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%b required 0", cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_clk: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_write();
      int c0, c, aw0, w0, b0;
      logic [1:0] op; logic [31:0] d; logic e;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
      send_cmd(2'b00, 32'h5000_0000, 32'h1, c0);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_busy: cmd_ready=%b required 0", cmd_ready);
      end
      get_rsp(op, d, e, c);
      checks++;
      if (c - c0 != 3) begin
         errors++;
         $display("FAIL write_latency: got %0d required 3", c - c0);
      end
      checks++;
      if ({op, d, e} !== {2'b00, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL write_rsp: op=%h d=%h e=%b required 0/0/0", op, d, e);
      end
      checks++;
      if ({aw_addr_l, w_data_l, w_strb_l} !== {32'h5000_0000, 32'h1, 4'hF}) begin
         errors++;
         $display("FAIL write_bus: awaddr=%h wdata=%h wstrb=%h required 50000000/1/f",
                  aw_addr_l, w_data_l, w_strb_l);
      end
      checks++;
      if ((aw_hs_n - aw0) != 1 || (w_hs_n - w0) != 1 || (b_hs_n - b0) != 1) begin
         errors++;
         $display("FAIL write_count: aw=%0d w=%0d b=%0d required 1/1/1",
                  aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0);
      end
   endtask

   task automatic test_read();
      int c0, c;
      logic [1:0] op; logic [31:0] d; logic e;
      send_cmd(2'b01, 32'h5000_0000, 32'hDEAD_BEEF, c0);
      get_rsp(op, d, e, c);
      checks++;
      if ({op, d, e} !== {2'b01, 32'h1, 1'b0} || c - c0 != 3) begin
         errors++;
         $display("FAIL read_back: op=%h d=%h e=%b lat=%0d required 1/00000001/0/3", op, d, e, c - c0);
      end
      rresp_cfg = 2'b10;
      send_cmd(2'b01, 32'h5000_0000, 32'h0, c0);
      get_rsp(op, d, e, c);
      rresp_cfg = 2'b00;
      checks++;
      if ({op, d, e} !== {2'b01, 32'h1, 1'b1}) begin
         errors++;
         $display("FAIL read_slverr: op=%h d=%h e=%b required 1/00000001/1", op, d, e);
      end
      bresp_cfg = 2'b10;
      send_cmd(2'b00, 32'h5000_0004, 32'h55, c0);
      get_rsp(op, d, e, c);
      bresp_cfg = 2'b00;
      checks++;
      if ({op, d, e} !== {2'b00, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL write_slverr: op=%h d=%h e=%b required 0/0/1", op, d, e);
      end
   endtask

   task automatic test_poll_match();
      int c0, c, a0;
      logic [1:0] op; logic [31:0] d; logic e;
      seq[0] = 32'h0; seq[1] = 32'h0; seq[2] = 32'h4; seq[3] = 32'h0;
      seq_base = ar_hs_n; seq_en = 1'b1; a0 = ar_hs_n;
      send_cmd(2'b10, 32'h4000_0004, 32'h4, c0);
      get_rsp(op, d, e, c);
      seq_en = 1'b0;
      checks++;
      if ({op, d, e} !== {2'b10, 32'h4, 1'b0}) begin
         errors++;
         $display("FAIL poll_match_rsp: op=%h d=%h e=%b required 2/00000004/0", op, d, e);
      end
      checks++;
      if ((ar_hs_n - a0) != 3 || c - c0 != 7) begin
         errors++;
         $display("FAIL poll_match_reads: ar=%0d lat=%0d required 3/7", ar_hs_n - a0, c - c0);
      end
      checks++;
      if (m_axi_araddr !== 32'h4000_0004) begin
         errors++;
         $display("FAIL poll_addr: araddr=%h required 40000004", m_axi_araddr);
      end
   endtask

   task automatic test_poll_timeout();
      int c0, c, a0;
      logic [1:0] op; logic [31:0] d; logic e;
      seq[0] = 32'h1; seq[1] = 32'h1; seq[2] = 32'h1; seq[3] = 32'h1;
      seq_base = ar_hs_n; seq_en = 1'b1; a0 = ar_hs_n;
      send_cmd(2'b10, 32'h4000_0004, 32'h4, c0);
      get_rsp(op, d, e, c);
      checks++;
      if ({op, d, e} !== {2'b10, 32'h1, 1'b1} || (ar_hs_n - a0) != 4 || c - c0 != 9) begin
         errors++;
         $display("FAIL poll_timeout: op=%h d=%h e=%b ar=%0d lat=%0d required 2/00000001/1/4/9",
                  op, d, e, ar_hs_n - a0, c - c0);
      end
      // Zero mask never matches, even on all-ones data
      seq[0] = 32'hFFFF_FFFF; seq[1] = 32'hFFFF_FFFF; seq[2] = 32'hFFFF_FFFF; seq[3] = 32'hFFFF_FFFF;
      seq_base = ar_hs_n; a0 = ar_hs_n;
      send_cmd(2'b10, 32'h4000_0004, 32'h0, c0);
      get_rsp(op, d, e, c);
      checks++;
      if ({d, e} !== {32'hFFFF_FFFF, 1'b1} || (ar_hs_n - a0) != 4) begin
         errors++;
         $display("FAIL poll_mask0: d=%h e=%b ar=%0d required ffffffff/1/4", d, e, ar_hs_n - a0);
      end
      // Bus error on first poll read ends the poll at once
      seq[0] = 32'h0; seq_base = ar_hs_n; a0 = ar_hs_n; rresp_cfg = 2'b11;
      send_cmd(2'b10, 32'h4000_0004, 32'h4, c0);
      get_rsp(op, d, e, c);
      rresp_cfg = 2'b00; seq_en = 1'b0;
      checks++;
      if (e !== 1'b1 || (ar_hs_n - a0) != 1) begin
         errors++;
         $display("FAIL poll_buserr: e=%b ar=%0d required 1/1", e, ar_hs_n - a0);
      end
   endtask

   task automatic test_indep_aw_w_stall();
      int c0, c, awv0, wv0, b0, bus0;
      logic [1:0] op; logic [31:0] d; logic e;
      aw_delay = 3; rsp_ready = 1'b0;
      awv0 = awv_n; wv0 = wv_n; b0 = b_hs_n;
      send_cmd(2'b00, 32'h5000_000C, 32'hCAFE_F00D, c0);
      get_rsp(op, d, e, c);
      aw_delay = 0;
      checks++;
      if ((awv_n - awv0) != 4 || (wv_n - wv0) != 1 || (b_hs_n - b0) != 1 || c - c0 != 6) begin
         errors++;
         $display("FAIL indep_aw_w: awv=%0d wv=%0d b=%0d lat=%0d required 4/1/1/6",
                  awv_n - awv0, wv_n - wv0, b_hs_n - b0, c - c0);
      end
      bus0 = bus_n;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, cmd_ready, rsp_op, rsp_data, rsp_err} !== {1'b1, 1'b0, 2'b00, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: rv=%b rdy=%b op=%h d=%h e=%b required 1/0/0/0/0",
                     i, rsp_valid, cmd_ready, rsp_op, rsp_data, rsp_err);
         end
      end
      checks++;
      if (bus_n != bus0) begin
         errors++;
         $display("FAIL stall_bus: active cycles=%0d required 0", bus_n - bus0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL stall_release: cmd_ready,rsp_valid=%b required 10", {cmd_ready, rsp_valid});
      end
   endtask

   task automatic test_back_to_back();
      int c0a, ca, c0b, cb;
      logic [1:0] op; logic [31:0] d; logic e;
      send_cmd(2'b00, 32'h5000_0010, 32'h1234_5678, c0a);
      get_rsp(op, d, e, ca);
      send_cmd(2'b01, 32'h5000_0010, 32'h0, c0b);
      get_rsp(op, d, e, cb);
      checks++;
      if (c0b - ca != 1 || d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL back_to_back: gap=%0d d=%h required 1/12345678", c0b - ca, d);
      end
   endtask

   task automatic test_reset_mid_write();
      int c0, c, n, aw0, ar0;
      logic [1:0] op; logic [31:0] d; logic e;
      b_stall = 1'b1;
      send_cmd(2'b00, 32'h5000_0008, 32'hA5, c0);
      n = 0;
      while (!m_axi_bready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (m_axi_bready !== 1'b1) begin
         errors++;
         $display("FAIL midwr_reach: bready=%b required 1", m_axi_bready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_err, m_axi_awvalid, m_axi_wvalid,
           m_axi_bready, m_axi_arvalid, m_axi_rready, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== 110'h0) begin
         errors++;
         $display("FAIL midwr_reset: rdy=%b bready=%b awaddr=%h wdata=%h wstrb=%h required all 0",
                  cmd_ready, m_axi_bready, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
      end
      @(negedge clk); @(negedge clk);
      b_stall = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      send_cmd(2'b00, 32'h5000_0008, 32'h77, c0);
      get_rsp(op, d, e, c);
      checks++;
      if ({op, d, e} !== {2'b00, 32'h0, 1'b0} || c - c0 != 3) begin
         errors++;
         $display("FAIL postrst_write: op=%h d=%h e=%b lat=%0d required 0/0/0/3", op, d, e, c - c0);
      end
      send_cmd(2'b01, 32'h5000_0008, 32'h0, c0);
      get_rsp(op, d, e, c);
      checks++;
      if (d !== 32'h77) begin
         errors++;
         $display("FAIL postrst_read: d=%h required 00000077", d);
      end
      aw0 = aw_hs_n; ar0 = ar_hs_n;
      send_cmd(2'b11, 32'h5000_0008, 32'hFFFF_FFFF, c0);
      get_rsp(op, d, e, c);
      checks++;
      if ({op, d, e} !== {2'b11, 32'h0, 1'b1} || c - c0 != 1) begin
         errors++;
         $display("FAIL illegal_rsp: op=%h d=%h e=%b lat=%0d required 3/0/1/1", op, d, e, c - c0);
      end
      checks++;
      if (aw_hs_n != aw0 || ar_hs_n != ar0) begin
         errors++;
         $display("FAIL illegal_bus: aw=%0d ar=%0d required 0/0", aw_hs_n - aw0, ar_hs_n - ar0);
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_data = 32'h0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) seq[i] = 32'h0;
      test_reset();
      test_write();
      test_read();
      test_poll_match();
      test_poll_timeout();
      test_indep_aw_w_stall();
      test_back_to_back();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
